// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit between a request/response port and a single-cycle memory
// Byte/half accesses and read-modify-write stores exist only when MEM_ACCESS_SUBWORD_EN is defined.
module mem_access_unit #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [31:0]   mem_wd,
  input  logic [31:0]   mem_rd
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ     = 3'd1,
`ifdef MEM_ACCESS_SUBWORD_EN
    RMW_READ = 3'd2,
`endif
    WRITE    = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic          misalign;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [31:0]   load_data;
  logic [31:0]   store_data;
  logic [AW-1:0] word_addr;

  assign word_addr = {addr_q[AW-1:2], 2'b00};

  always_comb begin
    misalign = 1'b1;
    case (req_size)
      2'b10:   misalign = (req_addr[1:0] != 2'b00);
`ifdef MEM_ACCESS_SUBWORD_EN
      2'b01:   misalign = req_addr[0];
      2'b00:   misalign = 1'b0;
`endif
      default: misalign = 1'b1;
    endcase
  end

`ifdef MEM_ACCESS_SUBWORD_EN
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] rmw_q;
  logic [4:0]  lane_shift;
  logic [15:0] rd_lane;
  logic [31:0] lane_mask;

  assign lane_shift = {addr_q[1:0], 3'b000};
  assign rd_lane    = 16'(mem_rd >> lane_shift);
  assign lane_mask  = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_shift;

  always_comb begin
    case (size_q)
      2'b00:   load_data = {{24{signed_q & rd_lane[7]}}, rd_lane[7:0]};
      2'b01:   load_data = {{16{signed_q & rd_lane[15]}}, rd_lane};
      default: load_data = mem_rd;
    endcase
  end

  // Sub-word stores merge the new lane into the word captured in RMW_READ.
  assign store_data = (size_q == 2'b10) ? wdata_q
                    : ((rmw_q & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask));
`else
  logic unused_subword;
  assign unused_subword = &{1'b0, req_signed, addr_q[1:0]};
  assign load_data      = mem_rd;
  assign store_data     = wdata_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_we    = 1'b0;
    mem_a     = '0;
    mem_wd    = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (misalign)                state_nxt = RESP;
          else if (!req_we)            state_nxt = READ;
`ifdef MEM_ACCESS_SUBWORD_EN
          else if (req_size != 2'b10)  state_nxt = RMW_READ;
`endif
          else                         state_nxt = WRITE;
        end
      end
      READ: begin
        mem_a     = word_addr;
        state_nxt = RESP;
      end
`ifdef MEM_ACCESS_SUBWORD_EN
      RMW_READ: begin
        mem_a     = word_addr;
        state_nxt = WRITE;
      end
`endif
      WRITE: begin
        mem_we    = 1'b1;
        mem_a     = word_addr;
        mem_wd    = store_data;
        state_nxt = RESP;
      end
      RESP: if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
`ifdef MEM_ACCESS_SUBWORD_EN
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      rmw_q    <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          addr_q   <= req_addr;
          wdata_q  <= req_wdata;
          err_q    <= misalign;
          rdata_q  <= '0;
`ifdef MEM_ACCESS_SUBWORD_EN
          size_q   <= req_size;
          signed_q <= req_signed;
`endif
        end
        READ: rdata_q <= load_data;
`ifdef MEM_ACCESS_SUBWORD_EN
        RMW_READ: rmw_q <= mem_rd;
`endif
        default: ;
      endcase
    end
  end

  // Response fields are gated so nothing stale leaks out outside RESP.
  assign resp_valid = (state == RESP);
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;
  assign resp_err   = resp_valid & err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
// Byte/half rows expect errors unless MEM_ACCESS_SUBWORD_EN is defined.
module tb_mem_access_unit;

`ifdef MEM_ACCESS_SUBWORD_EN
  localparam bit SUBWORD = 1'b1;
`else
  localparam bit SUBWORD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  logic [31:0] mem [64];
  logic        mem_init;
  int          wr_cnt;
  int          errors = 0;
  int          checks = 0;

  mem_access_unit #(.AW(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  logic unused_tb;
  assign unused_tb = ^{mem_a[31:8], mem_a[1:0]};
  assign mem_rd = mem[mem_a[7:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[26] <= 32'hCAFE_F00D;
      wr_cnt  <= 0;
    end else if (mem_we) begin
      mem[mem_a[7:2]] <= mem_wd;
      wr_cnt          <= wr_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Issues one request from a negedge and returns the response; consumes it if resp_ready=1.
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic err, output int lat, output int wr);
    int w0;
    w0 = wr_cnt;
    for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    lat = 99;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk);
      if (resp_valid) begin lat = i; break; end
    end
    rd  = resp_rdata;
    err = resp_err;
    @(posedge clk); #1;
    wr = wr_cnt - w0;
    @(negedge clk);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          writes;
    logic [31:0] mem;
    logic        rd_mem;
  } vec_t;

  vec_t        v [16];
  logic [31:0] cur_mem, e_rd, rd, hold_rd;
  logic        e_err, err;
  int          e_lat, e_wr, lat, wr, w0;

  initial begin
    v[0]  = '{1'b1, 2'b10, 1'b0, 32'h64, 32'hABCD_1234, 32'h0,         1'b0, 2, 1, 32'hABCD_1234, 1'b0};
    v[1]  = '{1'b0, 2'b10, 1'b0, 32'h64, 32'h0,         32'h0,         1'b0, 2, 0, 32'h0,         1'b1};
    v[2]  = '{1'b0, 2'b00, 1'b1, 32'h66, 32'h0,         32'hFFFF_FFCD, 1'b0, 2, 0, 32'h0,         1'b0};
    v[3]  = '{1'b0, 2'b00, 1'b0, 32'h66, 32'h0,         32'h0000_00CD, 1'b0, 2, 0, 32'h0,         1'b0};
    v[4]  = '{1'b0, 2'b01, 1'b1, 32'h66, 32'h0,         32'hFFFF_ABCD, 1'b0, 2, 0, 32'h0,         1'b0};
    v[5]  = '{1'b0, 2'b01, 1'b0, 32'h64, 32'h0,         32'h0000_1234, 1'b0, 2, 0, 32'h0,         1'b0};
    v[6]  = '{1'b0, 2'b00, 1'b1, 32'h64, 32'h0,         32'h0000_0034, 1'b0, 2, 0, 32'h0,         1'b0};
    v[7]  = '{1'b0, 2'b10, 1'b0, 32'h65, 32'h0,         32'h0,         1'b1, 1, 0, 32'h0,         1'b0};
    v[8]  = '{1'b1, 2'b01, 1'b0, 32'h67, 32'h1111,      32'h0,         1'b1, 1, 0, 32'h0,         1'b0};
    v[9]  = '{1'b0, 2'b11, 1'b0, 32'h64, 32'h0,         32'h0,         1'b1, 1, 0, 32'h0,         1'b0};
    v[10] = '{1'b1, 2'b00, 1'b0, 32'h65, 32'h0000_005A, 32'h0,         1'b0, 3, 1, 32'hABCD_5A34, 1'b0};
    v[11] = '{1'b1, 2'b01, 1'b0, 32'h66, 32'h0000_BEEF, 32'h0,         1'b0, 3, 1, 32'hBEEF_5A34, 1'b0};
    v[12] = '{1'b0, 2'b00, 1'b1, 32'h67, 32'h0,         32'hFFFF_FFBE, 1'b0, 2, 0, 32'h0,         1'b0};
    v[13] = '{1'b1, 2'b00, 1'b0, 32'h64, 32'h1234_56FF, 32'h0,         1'b0, 3, 1, 32'hBEEF_5AFF, 1'b0};
    v[14] = '{1'b0, 2'b10, 1'b0, 32'h64, 32'h0,         32'h0,         1'b0, 2, 0, 32'h0,         1'b1};
    v[15] = '{1'b1, 2'b10, 1'b0, 32'h66, 32'h5555_5555, 32'h0,         1'b1, 1, 0, 32'h0,         1'b0};

    reset_n = 1'b0; mem_init = 1'b1; resp_ready = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    mem_init = 1'b0;
    chk("reset req_ready", {31'h0, req_ready}, 32'h1);
    chk("reset resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("reset resp_err", {31'h0, resp_err}, 32'h0);
    chk("reset resp_rdata", resp_rdata, 32'h0);
    chk("reset mem_we", {31'h0, mem_we}, 32'h0);
    chk("reset mem_a", mem_a, 32'h0);
    chk("reset mem_wd", mem_wd, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    cur_mem = 32'h0;
    for (int i = 0; i < 16; i++) begin
      e_rd = v[i].rd_mem ? cur_mem : v[i].rdata;
      e_err = v[i].err; e_lat = v[i].lat; e_wr = v[i].writes;
      if (!SUBWORD && v[i].size != 2'b10) begin
        e_rd = 32'h0; e_err = 1'b1; e_lat = 1; e_wr = 0;
      end
      if (e_wr != 0) cur_mem = v[i].mem;
      do_req(v[i].we, v[i].size, v[i].sgn, v[i].addr, v[i].wdata, rd, err, lat, wr);
      chk($sformatf("vec%0d rdata", i), rd, e_rd);
      chk($sformatf("vec%0d err", i), {31'h0, err}, {31'h0, e_err});
      chk($sformatf("vec%0d latency", i), lat, e_lat);
      chk($sformatf("vec%0d writes", i), wr, e_wr);
      chk($sformatf("vec%0d mem[0x64]", i), mem[25], cur_mem);
    end

    // Backpressure: response held 4 cycles while a second request waits.
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h64;
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 99;
    for (int i = 2; i <= 10; i++) begin
      @(posedge clk); @(negedge clk);
      if (resp_valid) begin lat = i; break; end
    end
    chk("bp latency", lat, 2);
    hold_rd = cur_mem;
    req_valid = 1'b1; req_addr = 32'h68;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp%0d resp_valid", i), {31'h0, resp_valid}, 32'h1);
      chk($sformatf("bp%0d rdata", i), resp_rdata, hold_rd);
      chk($sformatf("bp%0d req_ready", i), {31'h0, req_ready}, 32'h0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp release resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("bp release req_ready", {31'h0, req_ready}, 32'h1);
    lat = 99;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk);
      if (resp_valid) begin lat = i; break; end
    end
    chk("bp second latency", lat, 2);
    chk("bp second rdata", resp_rdata, 32'hCAFE_F00D);
    @(negedge clk);

    // Reset asserted mid-cycle while a word store sits in WRITE.
    w0 = wr_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h68; req_wdata = 32'h1111_2222;
    @(posedge clk); #1 req_valid = 1'b0;
    chk("rst mem_we in WRITE", {31'h0, mem_we}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst mem_we async", {31'h0, mem_we}, 32'h0);
    chk("rst mem_a async", mem_a, 32'h0);
    chk("rst req_ready async", {31'h0, req_ready}, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst mem[0x68] kept", mem[26], 32'hCAFE_F00D);
    chk("rst no write", wr_cnt - w0, 32'h0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst idle req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst idle resp_valid", {31'h0, resp_valid}, 32'h0);
    @(negedge clk);
    do_req(1'b0, 2'b10, 1'b0, 32'h68, 32'h0, rd, err, lat, wr);
    chk("post-rst load rdata", rd, 32'hCAFE_F00D);
    chk("post-rst load latency", lat, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter AW, default 32: width of the request and memory addresses.
REQ-002 SHALL have ports clk in 1 (system clock, rising edge) and reset_n in 1 (reset); one clock; reset asynchronous, active-low.
REQ-003 SHALL have port req_valid in 1: request present.
REQ-004 SHALL have port req_ready out 1: unit accepts a request.
REQ-005 SHALL have port req_we in 1: 1 = store, 0 = load.
REQ-006 SHALL have port req_size in 2: access size, 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-007 SHALL have port req_signed in 1: sign-extend a load result.
REQ-008 SHALL have port req_addr in AW: byte address.
REQ-009 SHALL have port req_wdata in 32: store data, right-aligned.
REQ-010 SHALL have port resp_valid out 1: response present.
REQ-011 SHALL have port resp_ready in 1: consumer accepts the response.
REQ-012 SHALL have port resp_rdata out 32: load result.
REQ-013 SHALL have port resp_err out 1: request rejected.
REQ-014 SHALL have memory-side ports mem_we out 1, mem_a out AW, mem_wd out 32 and mem_rd in 32; the memory reads combinationally and writes synchronously.

Function
REQ-015 SHALL implement the FSM states IDLE, READ, RMW_READ, WRITE and RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE, with acceptance at the rising edge where req_valid & req_ready; the request fields SHALL be latched at that edge.
REQ-017 SHALL detect misalignment: half with addr[0]=1; word with addr[1:0]!=0; size 11 always.
REQ-018 SHALL, for a misaligned or illegal request, go IDLE->RESP with resp_err=1 and resp_rdata=0; mem_we SHALL stay 0 and memory SHALL NOT change.
REQ-019 SHALL handle a load as IDLE->READ->RESP: READ drives mem_a={addr[AW-1:2],2'b00}, mem_we=0; mem_rd is captured at the end of READ.
REQ-020 SHALL select little-endian lanes on a load: byte = mem_rd[8*addr[1:0]+7 -: 8]; half = mem_rd[16*addr[1]+15 -: 16]; the result is sign-extended if req_signed, else zero-extended.
REQ-021 SHALL handle a word store as IDLE->WRITE->RESP: WRITE drives mem_we=1, mem_a as in REQ-019, mem_wd=req_wdata, and the write commits at the edge leaving WRITE.
REQ-022 SHALL handle a byte/half store as IDLE->RMW_READ->WRITE->RESP: RMW_READ captures mem_rd; WRITE drives the captured word with only the addressed lane replaced.
REQ-023 SHALL assert mem_we in the WRITE state only, for exactly one cycle per store.
REQ-024 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready=1; RESP->IDLE on that edge.
REQ-025 SHALL give store responses resp_rdata=0 and resp_err=0.
REQ-026 SHALL keep latency from acceptance edge to resp_valid at: error 1 cycle; load 2; word store 2; sub-word store 3.
REQ-027 SHALL NOT accept a new request in the same cycle a response is consumed; the next acceptance is earliest one cycle after RESP->IDLE.

Reset
REQ-028 SHALL, while reset_n=0, force state=IDLE and req_ready=1, with resp_valid, resp_err, resp_rdata, mem_we, mem_a and mem_wd all 0, independent of clk.
REQ-029 SHALL abort any in-flight access on reset assertion mid-operation; a store in WRITE SHALL NOT commit, because mem_we drops asynchronously.
REQ-030 SHALL treat the first rising edge after reset_n rises as a normal IDLE cycle.

Configuration
REQ-031 SHALL, with MEM_ACCESS_SUBWORD_EN defined, support byte/half sizes per REQ-020 and REQ-022.
REQ-032 SHALL, without MEM_ACCESS_SUBWORD_EN, omit RMW_READ and the lane logic and treat every size other than 10 as illegal per REQ-018.

Verification
REQ-033 SHALL cover word store then load: store 0xABCD1234 to 0x64, then load word 0x64 -> mem_we pulses once; resp_rdata=0xABCD1234, resp_err=0, latency 2.
REQ-034 SHALL cover signed and unsigned byte loads: memory at 0x64 = 0xABCD1234; load byte 0x66 signed -> 0xFFFFFFCD; unsigned -> 0x000000CD; load half 0x66 signed -> 0xFFFFABCD.
REQ-035 SHALL cover a sub-word store: store byte 0x5A to 0x65 over 0xABCD1234 -> one write of 0xABCD5A34, resp at 3 cycles; a store half of 0xBEEF to 0x66 then gives 0xBEEF5A34.
REQ-036 SHALL cover misaligned requests: load word 0x65 and store half 0x67 -> resp_err=1 after 1 cycle, mem_we never 1, memory unchanged.
REQ-037 SHALL cover response backpressure: resp_ready=0 for 4 cycles -> resp_valid and data held, req_ready=0, and a second req_valid is not accepted until after release.
REQ-038 SHALL cover reset during WRITE: assert reset_n=0 mid-cycle in WRITE -> mem_we falls immediately, target word keeps its old value, and state is IDLE after release.
